// File: rtl/serial_ctrl_pkg.sv
// Shared state encoding and protocol byte constants for the serial command controller.
package serial_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_START,
        ST_RUN,
        ST_RESP
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: o_expire fires on the TIMEOUT_CYC-th consecutive enabled cycle
// without a clear; a clear in the same cycle wins over expiry.
module byte_timeout #(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_enable && !i_clear && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear || o_expire)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/serial_cmd_ctrl.sv
// Receives sync/payload/checksum packets over UART, launches the serial-out engine
// on a good packet and answers every packet with a single ACK or NAK byte.
module serial_cmd_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int PACK_NUM    = 9,
    parameter int TIMEOUT_CYC = 100_000,
    parameter int PAY_W       = 8 * (PACK_NUM - 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done_tick,
    output logic             o_start_tick,
    output logic [PAY_W-1:0] o_payload,
    input  logic             i_done_tick,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_done_tick,
    output logic             o_busy,
    output logic             o_drop_tick
);
    localparam int CNT_W = $clog2(PACK_NUM + 1);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_xor;
    logic [PAY_W-1:0]   r_shadow;
    logic [PAY_W-1:0]   r_payload;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_drop;

    logic w_rx_accept, w_last, w_sum_ok, w_expire, w_clear, w_enter_resp, w_sync;

    assign w_sync       = (i_rx_data == SYNC_BYTE);
    assign w_rx_accept  = i_rx_done_tick && (r_state == ST_RECV);
    assign w_last       = w_rx_accept && (r_count == CNT_W'(PACK_NUM - 1));
    assign w_sum_ok     = ((r_xor ^ i_rx_data) == 8'h00);
    assign w_clear      = w_rx_accept || (r_state != ST_RECV);
    assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

    byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (r_state == ST_RECV),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // A byte arriving in the expiry cycle is accepted: the rx tick is tested first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_rx_done_tick && w_sync) w_next = ST_RECV;
            ST_RECV: begin
                if (w_last)
                    w_next = w_sum_ok ? ST_START : ST_RESP;
                else if (!i_rx_done_tick && w_expire)
                    w_next = ST_RESP;
            end
            ST_START: w_next = ST_RUN;
            ST_RUN:   if (i_done_tick) w_next = ST_RESP;
            ST_RESP:  if (i_tx_done_tick) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_start_tick = (r_state == ST_START);
        o_busy       = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_xor      <= '0;
            r_shadow   <= '0;
            r_payload  <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop     <= i_rx_done_tick &&
                          (((r_state == ST_IDLE) && !w_sync) ||
                           (r_state == ST_START) || (r_state == ST_RUN) || (r_state == ST_RESP));
            r_tx_start <= w_enter_resp;
            if (w_enter_resp)
                r_tx_data <= (r_state == ST_RUN) ? ACK_BYTE : NAK_BYTE;
            // Payload is presented for the whole START cycle alongside o_start_tick.
            if (w_next == ST_START)
                r_payload <= r_shadow;

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_done_tick && w_sync) begin
                        r_count  <= CNT_W'(1);
                        r_xor    <= SYNC_BYTE;
                        r_shadow <= '0;
                    end
                end
                ST_RECV: begin
                    if (w_rx_accept) begin
                        if (w_last) begin
                            r_count <= '0;
                            r_xor   <= '0;
                        end else begin
                            r_shadow <= PAY_W'({r_shadow, i_rx_data});
                            r_xor    <= r_xor ^ i_rx_data;
                            r_count  <= r_count + CNT_W'(1);
                        end
                    end else if (w_expire) begin
                        r_count  <= '0;
                        r_xor    <= '0;
                        r_shadow <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_payload   = r_payload;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_drop_tick = r_drop;

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Bench for serial_cmd_ctrl: table-driven packets, hand-written corner sequences and
// random packets whose outcome is predicted from the packet bytes alone.
module tb_serial_cmd_ctrl;
    localparam int TO = 20;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk, rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_done_tick, i_done_tick, i_tx_done_tick;
    logic        o_start_tick, o_tx_start, o_busy, o_drop_tick;
    logic [55:0] o_payload;
    logic [7:0]  o_tx_data;

    serial_cmd_ctrl #(.PACK_NUM(9), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_done_tick(i_rx_done_tick),
        .o_start_tick(o_start_tick), .o_payload(o_payload),
        .i_done_tick(i_done_tick),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done_tick(i_tx_done_tick),
        .o_busy(o_busy), .o_drop_tick(o_drop_tick)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [55:0] model_pay;
    logic [55:0] prev_pay;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        step();
        i_rx_done_tick = 1'b0;
    endtask

    // Closes out a RESP phase: single tx pulse, stable data, drop while waiting, back to idle.
    task automatic finish_resp(input logic [7:0] exp_tx);
        step();
        mid();
        chk("tx_once", o_tx_start, 0);
        chk("resp_busy", o_busy, 1);
        chk("tx_hold", o_tx_data, exp_tx);
        step();
        send_byte(8'hA5);
        mid();
        chk("drop_resp", o_drop_tick, 1);
        step();
        i_tx_done_tick = 1'b1;
        step();
        i_tx_done_tick = 1'b0;
        mid();
        chk("idle_after_resp", o_busy, 0);
        step();
    endtask

    task automatic run_pkt(input logic [71:0] pkt, input int gap, input logic ok, input logic [55:0] pay);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) repeat (gap) step();
            send_byte(pkt[8*(8-i) +: 8]);
        end
        mid();
        chk("start_latency", o_start_tick, ok);
        chk("nak_tx_start", o_tx_start, !ok);
        if (ok) begin
            chk("payload", o_payload, pay);
            model_pay = pay;
            step();
            mid();
            chk("run_busy", o_busy, 1);
            chk("start_once", o_start_tick, 0);
            step();
            send_byte(8'($urandom));
            mid();
            chk("drop_run", o_drop_tick, 1);
            chk("run_no_tx", o_tx_start, 0);
            step();
            repeat ($urandom_range(0, 3)) step();
            i_done_tick = 1'b1;
            step();
            i_done_tick = 1'b0;
            mid();
            chk("ack_tx_start", o_tx_start, 1);
            chk("ack_data", o_tx_data, ACK);
            finish_resp(ACK);
        end else begin
            chk("nak_data", o_tx_data, NAK);
            chk("payload_keep", o_payload, model_pay);
            finish_resp(NAK);
        end
    endtask

    // Sends the first nb bytes of a packet, then expects a NAK after TO silent cycles.
    task automatic run_trunc(input logic [71:0] pkt, input int nb, input int gap);
        int j;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) repeat (gap) step();
            send_byte(pkt[8*(8-i) +: 8]);
        end
        for (j = 1; j <= TO + 5; j++) begin
            mid();
            if (o_tx_start) break;
            step();
        end
        chk("timeout_latency", j, TO + 1);
        chk("timeout_nak", o_tx_data, NAK);
        chk("timeout_payload_keep", o_payload, model_pay);
        finish_resp(NAK);
    endtask

    // o_payload may only move in a cycle that carries o_start_tick.
    always @(negedge clk) begin
        if (!rst && o_payload !== prev_pay)
            chk("payload_hold", o_start_tick, 1);
        prev_pay = o_payload;
    end

    typedef struct {
        logic [71:0] pkt;
        logic        ok;
        logic [55:0] pay;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b, x, last;
        logic [71:0] pkt;
        logic [55:0] pay;
        int kind, gap, nn;

        tbl[0] = '{72'hA5_11_22_33_44_55_66_77_A5, 1'b1, 56'h11_22_33_44_55_66_77};
        tbl[1] = '{72'hA5_11_22_33_44_55_66_77_A4, 1'b0, 56'h0};
        tbl[2] = '{72'hA5_00_00_00_00_00_00_00_A5, 1'b1, 56'h0};
        tbl[3] = '{72'hA5_FF_FF_FF_FF_FF_FF_FF_5A, 1'b1, 56'hFF_FF_FF_FF_FF_FF_FF};
        tbl[4] = '{72'hA5_A5_01_02_03_04_05_06_07, 1'b1, 56'hA5_01_02_03_04_05_06};

        rst = 0; i_rx_data = 0; i_rx_done_tick = 0; i_done_tick = 0; i_tx_done_tick = 0;
        model_pay = '0;
        prev_pay  = '0;
        #2 rst = 1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_start_tick, 0);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_drop", o_drop_tick, 0);
        chk("rst_payload", o_payload, 0);
        chk("rst_tx_data", o_tx_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        send_byte(8'h3C);
        mid();
        chk("drop_idle", o_drop_tick, 1);
        chk("drop_idle_busy", o_busy, 0);
        step();
        i_done_tick = 1'b1;
        step();
        i_done_tick = 1'b0;
        mid();
        chk("done_ignored_busy", o_busy, 0);
        chk("done_ignored_tx", o_tx_start, 0);
        step();

        for (int i = 0; i < 5; i++)
            run_pkt(tbl[i].pkt, 1, tbl[i].ok, tbl[i].pay);

        run_trunc(tbl[0].pkt, 3, 0);
        run_pkt(tbl[0].pkt, 0, 1'b1, tbl[0].pay);

        // Every byte lands in the exact cycle the watchdog would expire.
        run_pkt(72'hA5_01_02_03_04_05_06_07_A5, TO - 1, 1'b1, 56'h01_02_03_04_05_06_07);

        for (int i = 0; i < 5; i++)
            send_byte(tbl[0].pkt[8*(8-i) +: 8]);
        mid();
        chk("mid_pkt_busy", o_busy, 1);
        step();
        rst = 1;
        #1;
        model_pay = '0;
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_payload", o_payload, 0);
        chk("rst_mid_tx_data", o_tx_data, 0);
        chk("rst_mid_tx_start", o_tx_start, 0);
        chk("rst_mid_drop", o_drop_tick, 0);
        step();
        rst = 0;
        run_pkt(tbl[0].pkt, 1, 1'b1, tbl[0].pay);

        for (int t = 0; t < 25; t++) begin
            nn = $urandom_range(0, 2);
            for (int k = 0; k < nn; k++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h3C;
                send_byte(b);
                mid();
                chk("rand_drop_idle", o_drop_tick, 1);
                step();
            end
            pkt = '0;
            pkt[71:64] = 8'hA5;
            x = 8'hA5;
            pay = '0;
            for (int i = 1; i < 8; i++) begin
                b = 8'($urandom);
                pay = {pay[47:0], b};
                x = x ^ b;
                pkt[8*(8-i) +: 8] = b;
            end
            last = x;
            kind = $urandom_range(0, 9);
            if (kind >= 2 && kind <= 4)
                last = last ^ (8'h01 << $urandom_range(0, 7));
            pkt[7:0] = last;
            gap = ($urandom_range(0, 4) == 0) ? TO - 1 : $urandom_range(0, 3);
            if (kind < 2)
                run_trunc(pkt, $urandom_range(1, 8), gap);
            else
                run_pkt(pkt, gap, kind > 4, pay);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_cmd_ctrl.md
SERIAL_CMD_CTRL -- requirements
Module: serial_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter PACK_NUM, default 9, meaning total bytes per command packet: sync, payload, checksum.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100_000, meaning the maximum number of clk cycles allowed between received bytes of one packet.
REQ-003 The block SHALL have parameter PAY_W, default 8*(PACK_NUM-2), meaning the payload width in bits.
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 The block SHALL have port i_rx_data, input, 8, the UART receive byte.
REQ-007 The block SHALL have port i_rx_done_tick, input, 1, a one-cycle strobe marking i_rx_data valid.
REQ-008 The block SHALL have port o_start_tick, output, 1, a one-cycle start pulse to the serial-out engine.
REQ-009 The block SHALL have port o_payload, output, PAY_W, the command payload driven to the serial-out engine.
REQ-010 The block SHALL have port i_done_tick, input, 1, the serial-out engine completion strobe.
REQ-011 The block SHALL have port o_tx_start, output, 1, a one-cycle UART transmit request.
REQ-012 The block SHALL have port o_tx_data, output, 8, the response byte.
REQ-013 The block SHALL have port i_tx_done_tick, input, 1, the UART transmit completion strobe.
REQ-014 The block SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port o_drop_tick, output, 1, a one-cycle pulse when a received byte is discarded.

Function
REQ-016 The state machine SHALL have exactly the states IDLE, RECV, START, RUN and RESP.
REQ-017 In IDLE, i_rx_done_tick with byte 0xA5 SHALL move the FSM to RECV with byte count=1 and running XOR=0xA5.
REQ-018 In IDLE, a non-0xA5 byte SHALL be ignored and SHALL pulse o_drop_tick.
REQ-019 In RECV, each i_rx_done_tick SHALL shift the byte into the shadow buffer, first payload byte in the MSBs, SHALL XOR it into the running checksum, and SHALL increment the count.
REQ-020 On acceptance of byte index PACK_NUM-1, the block SHALL go to START if (XOR ^ byte)==0x00, else to RESP with o_tx_data=0x15 (NAK).
REQ-021 In RECV, TIMEOUT_CYC cycles without i_rx_done_tick SHALL go to RESP with NAK, and the partial buffer SHALL be discarded.
REQ-022 The timeout counter SHALL clear on every accepted byte and on entry to RECV.
REQ-023 START SHALL last exactly one cycle: o_start_tick=1, o_payload loaded from the shadow buffer, then go to RUN.
REQ-024 Latency from the last-byte tick (cycle N) to o_start_tick SHALL be 1 cycle (asserted in cycle N+1).
REQ-025 o_payload SHALL change only in START and SHALL hold its value at all other times.
REQ-026 RUN SHALL wait for i_done_tick, then go to RESP with o_tx_data=0x06 (ACK).
REQ-027 i_done_tick outside RUN SHALL be ignored.
REQ-028 On entry, RESP SHALL assert o_tx_start for exactly one cycle, SHALL hold o_tx_data stable, and SHALL wait for i_tx_done_tick before returning to IDLE.
REQ-029 i_rx_done_tick in START, RUN or RESP SHALL be discarded and SHALL pulse o_drop_tick.
REQ-030 i_rx_done_tick coincident with timeout expiry SHALL take priority: the byte is accepted and the counter is cleared.
REQ-031 A 0xA5 byte within RECV SHALL be treated as ordinary data, with no resynchronisation.

Reset
REQ-032 Asserting rst at any time, including mid-packet or in RUN, SHALL immediately force IDLE with count=0, XOR=0, timeout=0, shadow buffer=0, o_payload=0, o_tx_data=0, and o_start_tick, o_tx_start, o_busy and o_drop_tick all 0.
REQ-033 After rst deasserts, the first accepted event SHALL be on the next clk rising edge.

Structure
REQ-034 Package serial_ctrl_pkg SHALL hold the state encoding and the constants SYNC_BYTE=0xA5, ACK_BYTE=0x06 and NAK_BYTE=0x15.
REQ-035 The inter-byte timeout SHALL be a sub-module byte_timeout, with inputs clear and enable, output expire, and width $clog2(TIMEOUT_CYC+1).
REQ-036 All other logic SHALL be flat in serial_cmd_ctrl.

Verification
REQ-037 Valid packet: bytes A5 11 22 33 44 55 66 77 A5 -> o_start_tick one cycle after the last tick, o_payload=0x11223344556677; then i_done_tick -> o_tx_data=0x06 with one o_tx_start pulse; then i_tx_done_tick -> IDLE.
REQ-038 Bad checksum: the same packet with last byte 0xA4 -> no o_start_tick, o_tx_data=0x15, and o_payload unchanged from its prior value.
REQ-039 Timeout: A5 11 22 followed by 100_000 idle cycles -> NAK issued; a following valid packet is processed normally.
REQ-040 Drops: bytes 0x3C in IDLE, and bytes received during RUN, each produce one o_drop_tick and cause no state change.
REQ-041 Reset mid-packet: rst pulsed after byte 5 -> all outputs 0 and IDLE; the next full valid packet -> correct payload and ACK.
REQ-042 Boundary: a byte tick in the exact cycle of timeout expiry -> the byte is accepted and no NAK is issued.
